alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 4-bit ALU operation code produced by the execute-stage ALU control decoder. It performs the operation on two 32-bit operands.
- ADD/SUB/AND/OR/SLT complete in one cycle.
- MUL runs as an iterative shift-add sequence and holds `busy` high so the hazard unit stalls IF/ID/EX.
- Sits between the ID/EX pipeline register and the EX/MEM pipeline register.

---
 rtl/alu_exec_unit_pkg.sv | 16 +
 rtl/alu_exec_unit_mul_iter.sv | 44 ++++
 rtl/alu_exec_unit.sv | 95 +++++++++
 tb/tb_alu_exec_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: opcodes, FSM states and default width shared by the execute-stage ALU
package alu_exec_unit_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_op_e;
  typedef enum logic {IDLE, MUL_RUN} alu_state_e;
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL};
  endfunction
endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: shift-add multiply datapath, one iteration per step; MUL_EARLY_EXIT_EN stops once the multiplier empties
module mul_iter import alu_exec_unit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] product_o,
  output logic              done_o
);
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // accumulator value after the current iteration; the final one is the product
  assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MUL_EARLY_EXIT_EN
  assign done_o = mplier_q[DATA_W-1:1] == '0;
`else
  assign done_o = cnt_q == CNT_W'(DATA_W - 1);
`endif
  always_comb begin
    mcand_d  = load_i ? a_i : clear_i ? '0 : step_i ? mcand_q << 1 : mcand_q;
    mplier_d = load_i ? b_i : clear_i ? '0 : step_i ? mplier_q >> 1 : mplier_q;
    acc_d    = (load_i || clear_i) ? '0 : step_i ? product_o : acc_q;
    cnt_d    = (load_i || clear_i) ? '0 : step_i ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith ops and an iterative MUL that stalls via busy
// Optional MUL_EARLY_EXIT_EN (in mul_iter) ends MUL once the remaining multiplier is zero.
module alu_exec_unit import alu_exec_unit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        alu_control_opr,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal_op
);
  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d, alu_res, product;
  logic              zero_q, zero_d, valid_q, valid_d, illegal_q, illegal_d;
  logic              load, step, clear, mul_done, slt;
  assign slt = $signed(src_a) < $signed(src_b);
  assign alu_res = alu_control_opr == ALU_AND ? src_a & src_b :
                   alu_control_opr == ALU_OR  ? src_a | src_b :
                   alu_control_opr == ALU_ADD ? src_a + src_b :
                   alu_control_opr == ALU_SUB ? src_a - src_b :
                   alu_control_opr == ALU_SLT ? {{(DATA_W-1){1'b0}}, slt} : '0;
  mul_iter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .clear_i  (clear),
    .a_i      (src_a),
    .b_i      (src_b),
    .product_o(product),
    .done_o   (mul_done)
  );
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    if (state_q == MUL_RUN) begin
      if (flush) begin
        state_d = IDLE;
        clear   = 1'b1;
      end else begin
        step = 1'b1;
        if (mul_done) begin
          state_d  = IDLE;
          result_d = product;
          zero_d   = product == '0;
          valid_d  = 1'b1;
        end
      end
    end else if (start && !flush) begin
      if (alu_control_opr == ALU_MUL) begin
        load    = 1'b1;
        state_d = MUL_RUN;
      end else begin
        result_d  = alu_res;
        zero_d    = alu_res == '0;
        valid_d   = 1'b1;
        illegal_d = !op_legal(alu_control_opr);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end
  assign busy         = state_q == MUL_RUN;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign illegal_op   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a plain-arithmetic reference model
module tb_alu_exec_unit;
  localparam int W = 32;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, result_valid, zero, illegal_op;
  logic [W-1:0] result;
  logic [W-1:0] exp_res = '0;
  int           checks = 0, errors = 0;

  alu_exec_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .alu_control_opr(op),
    .src_a          (a),
    .src_b          (b),
    .flush          (flush),
    .busy           (busy),
    .result_valid   (result_valid),
    .result         (result),
    .zero           (zero),
    .illegal_op     (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'b1000: return x * y;
      default: return '0;
    endcase
  endfunction

  function automatic logic legal(input logic [3:0] o);
    return o inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000};
  endfunction

  function automatic int exp_busy(input logic [W-1:0] y);
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
`ifndef MUL_EARLY_EXIT_EN
    n = W;
`endif
    return n;
  endfunction

  task automatic op_step(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = o; a = x; b = y;
    @(posedge clk); #1;
    exp_res = model(o, x, y);
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".zero"}, W'(zero), W'(exp_res == '0));
    chk({tag, ".valid"}, W'(result_valid), W'(1));
    chk({tag, ".illegal"}, W'(illegal_op), W'(!legal(o)));
    chk({tag, ".busy"}, W'(busy), W'(0));
  endtask

  task automatic idle_step(input string tag);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".idle_valid"}, W'(result_valid), W'(0));
    chk({tag, ".idle_illegal"}, W'(illegal_op), W'(0));
    chk({tag, ".idle_res"}, result, exp_res);
    chk({tag, ".idle_busy"}, W'(busy), W'(0));
  endtask

  task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int flush_at, input string tag);
    int n, vbad;
    n = 0; vbad = 0;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = 4'b1000; a = x; b = y;
    @(posedge clk); #1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (result_valid !== 1'b0) vbad++;
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      flush = (n == flush_at);
      @(posedge clk); #1;
    end
    chk({tag, ".valid_while_busy"}, W'(vbad), W'(0));
    if (flush_at > 0) begin
      chk({tag, ".busy_cycles"}, W'(n), W'(flush_at));
      chk({tag, ".valid"}, W'(result_valid), W'(0));
      chk({tag, ".res_held"}, result, exp_res);
    end else begin
      exp_res = x * y;
      chk({tag, ".busy_cycles"}, W'(n), W'(exp_busy(y)));
      chk({tag, ".valid"}, W'(result_valid), W'(1));
      chk({tag, ".res"}, result, exp_res);
      chk({tag, ".zero"}, W'(zero), W'(exp_res == '0));
    end
    idle_step(tag);
  endtask

  initial begin
    logic [3:0] o;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", W'(busy), W'(0));
    chk("reset.valid", W'(result_valid), W'(0));
    chk("reset.res", result, W'(0));
    chk("reset.zero", W'(zero), W'(0));
    chk("reset.illegal", W'(illegal_op), W'(0));
    @(negedge clk);
    rst = 1'b0;
    op_step(4'b0010, 5, 7, "add_5_7");
    idle_step("add_5_7");
    op_step(4'b0110, 7, 7, "sub_7_7");
    op_step(4'b0111, 32'hFFFF_FFFF, 1, "slt_m1_1");
    idle_step("slt_m1_1");
    run_mul(6, 7, 0, "mul_6_7");
    run_mul(32'hFFFF_FFFF, 2, 0, "mul_m1_2");
    run_mul(3, 5, 0, "mul_3_5");
    run_mul(32'h1234_5678, 0, 0, "mul_x_0");
    op_step(4'b0001, 32'h00F0, 32'h0F00, "or_pre_flush");
    run_mul(32'hDEAD_BEEF, 32'h8000_0001, 10, "mul_flush10");
    op_step(4'b1111, 32'hAAAA_5555, 32'h1234, "illegal_f");
    idle_step("illegal_f");
    op_step(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, "and_pre");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 4'b0010; a = 1; b = 1;
    @(posedge clk); #1;
    chk("flush_start.valid", W'(result_valid), W'(0));
    chk("flush_start.res", result, exp_res);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 4'b1111;
    @(posedge clk); #1;
    chk("flush_illegal.valid", W'(result_valid), W'(0));
    chk("flush_illegal.illegal", W'(illegal_op), W'(0));
    idle_step("after_flush");
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'b1000) o = 4'b0010;
      op_step(o, $urandom, ($urandom_range(0, 3) == 0) ? a : $urandom, "rand_op");
    end
    idle_step("rand_op");
    for (int i = 0; i < 4; i++) run_mul($urandom, $urandom >> $urandom_range(0, 31), 0, "rand_mul");
    op_step(4'b0010, 32'h100, 32'h23, "add_pre_rst");
    @(negedge clk);
    start = 1'b1; op = 4'b1000; a = 32'h55; b = 32'hF000_0003;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid.busy_before", W'(busy), W'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", W'(busy), W'(0));
    chk("rst_mid.res", result, W'(0));
    chk("rst_mid.zero", W'(zero), W'(0));
    chk("rst_mid.valid", W'(result_valid), W'(0));
    chk("rst_mid.illegal", W'(illegal_op), W'(0));
    exp_res = '0;
    @(negedge clk);
    rst = 1'b0;
    idle_step("after_rst");
    op_step(4'b0010, 32'hFFFF_FFFF, 1, "add_wrap");
    idle_step("add_wrap");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
